// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART receive path and the future transmit path.
//   rx_state_e     receiver FSM states
//   maj3()         3-sample majority vote
//   *_MIN / *_MAX  legal parameter ranges
//   cfg_legal()    checks one parameter set against those ranges
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    localparam int unsigned DATA_BITS_MIN  = 5;
    localparam int unsigned DATA_BITS_MAX  = 9;
    localparam int unsigned OVERSAMPLE_MIN = 8;
    localparam int unsigned STOP_BITS_MIN  = 1;
    localparam int unsigned STOP_BITS_MAX  = 2;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    function automatic bit cfg_legal(input int unsigned data_bits,
                                     input int unsigned oversample,
                                     input int unsigned stop_bits);
        return (data_bits >= DATA_BITS_MIN) && (data_bits <= DATA_BITS_MAX) &&
               (oversample >= OVERSAMPLE_MIN) && (oversample % 2 == 0) &&
               (stop_bits >= STOP_BITS_MIN) && (stop_bits <= STOP_BITS_MAX);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: input synchronizer, oversample counter and 3-sample bit vote.
//   clk, rst    clock, synchronous active-high reset
//   os_tick     oversample tick (baud x OVERSAMPLE)
//   rx          asynchronous serial line, idle high
//   count_clr   restarts the sample counter at 0 (start edge seen)
//   rxs         synchronized line
//   rxs_fall    rxs went 1 -> 0 this cycle
//   bit_strobe  a bit decision is made this cycle
//   bit_val     majority vote of the three mid-bit samples
module uart_rx_sampler
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic os_tick,
    input  logic rx,
    input  logic count_clr,
    output logic rxs,
    output logic rxs_fall,
    output logic bit_strobe,
    output logic bit_val
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);
    localparam logic [CW-1:0] C_MID  = CW'(OVERSAMPLE / 2);
    localparam logic [CW-1:0] C_S0   = CW'(OVERSAMPLE / 2 - 2);
    localparam logic [CW-1:0] C_S1   = CW'(OVERSAMPLE / 2 - 1);

    logic [1:0]    sync_q;
    logic          rxs_prev_q;
    logic [CW-1:0] c_q;
    logic          s0_q;
    logic          s1_q;

    assign rxs        = sync_q[1];
    assign rxs_fall   = rxs_prev_q & ~rxs;
    assign bit_strobe = os_tick & (c_q == C_MID);
    // The third sample is the live line on the deciding tick itself.
    assign bit_val    = maj3(s0_q, s1_q, rxs);

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= 2'b11;
            rxs_prev_q <= 1'b1;
            c_q        <= '0;
            s0_q       <= 1'b1;
            s1_q       <= 1'b1;
        end else begin
            sync_q     <= {sync_q[0], rx};
            rxs_prev_q <= rxs;
            // A start edge realigns the counter even if a tick lands on the same cycle.
            if (count_clr) begin
                c_q <= '0;
            end else if (os_tick) begin
                c_q <= (c_q == C_LAST) ? '0 : c_q + 1'b1;
            end
            if (os_tick && (c_q == C_S0)) s0_q <= rxs;
            if (os_tick && (c_q == C_S1)) s1_q <= rxs;
        end
    end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with a valid/ready holding register.
//   clk, rst      clock, synchronous active-high reset
//   os_tick       oversample tick, OVERSAMPLE pulses per bit
//   rx            asynchronous serial line, idle high
//   rx_data       received word, valid while rx_valid
//   rx_valid      word held until rx_valid & rx_ready
//   rx_ready      consumer accept
//   parity_err    parity status of the held word (0 without parity)
//   frame_err     one-cycle pulse: a stop bit voted low
//   overrun_err   one-cycle pulse: a frame finished while the previous word was unaccepted
// Build option: define UART_RX_PARITY_EN to expect one parity bit after the data bits.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 os_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun_err
);

    localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
    localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

    logic rxs, rxs_fall, bit_strobe, bit_val, count_clr;

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE)) u_sampler (
        .clk        (clk),
        .rst        (rst),
        .os_tick    (os_tick),
        .rx         (rx),
        .count_clr  (count_clr),
        .rxs        (rxs),
        .rxs_fall   (rxs_fall),
        .bit_strobe (bit_strobe),
        .bit_val    (bit_val)
    );

    rx_state_e            state_q, state_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [3:0]           cnt_q, cnt_d;
    logic                 stop_bad_q, stop_bad_d;
    logic                 load, frame_pulse;
    logic                 stop_bad_now;

    logic [DATA_BITS-1:0] rx_data_q;
    logic                 rx_valid_q, frame_err_q, overrun_err_q;
    logic                 handshake;

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_ODD = PARITY_ODD[0];
    logic par_err_q, par_err_d;     // status of the frame in flight
    logic parity_err_q;             // status of the held word
`else
    wire unused_parity_odd = PARITY_ODD[0];
`endif

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        stop_bad_d   = stop_bad_q;
        load         = 1'b0;
        frame_pulse  = 1'b0;
        count_clr    = 1'b0;
        stop_bad_now = stop_bad_q | ~bit_val;
`ifdef UART_RX_PARITY_EN
        par_err_d    = par_err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (rxs_fall) begin
                    count_clr = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (bit_strobe) begin
                    cnt_d   = '0;
                    state_d = bit_val ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_strobe) begin
                    shift_d = {bit_val, shift_q[DATA_BITS-1:1]};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d      = '0;
                        stop_bad_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                        state_d    = ST_PARITY;
`else
                        state_d    = ST_STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_strobe) begin
                    par_err_d = (^shift_q ^ bit_val) ^ PAR_ODD;
                    state_d   = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_strobe) begin
                    // All stop bits are sampled before deciding, so 2-stop frames
                    // report at most one framing error.
                    if (cnt_q == STOP_LAST) begin
                        if (stop_bad_now) begin
                            frame_pulse = 1'b1;
                            state_d     = ST_BREAK;
                        end else begin
                            load    = 1'b1;
                            state_d = ST_IDLE;
                        end
                    end else begin
                        cnt_d      = cnt_q + 4'd1;
                        stop_bad_d = stop_bad_now;
                    end
                end
            end
            ST_BREAK: begin
                if (rxs) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            shift_q    <= '0;
            cnt_q      <= '0;
            stop_bad_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            cnt_q      <= cnt_d;
            stop_bad_q <= stop_bad_d;
        end
    end

    assign handshake = rx_valid_q & rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
        end else begin
            frame_err_q   <= frame_pulse;
            overrun_err_q <= load & rx_valid_q & ~handshake;
            if (load && (!rx_valid_q || handshake)) begin
                rx_data_q  <= shift_q;
                rx_valid_q <= 1'b1;
            end else if (handshake) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
            if (load && (!rx_valid_q || handshake)) parity_err_q <= par_err_q;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign frame_err   = frame_err_q;
    assign overrun_err = overrun_err_q;

endmodule

// File: tb/tb_uart_rx_os.sv
module tb_uart_rx_os;

    localparam int DB  = 8;
    localparam int OS  = 16;
    localparam int SB  = 1;
    localparam int PODD = 0;
    localparam int M   = OS / 2;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          os_tick;
    logic          rx;
    logic [DB-1:0] rx_data;
    logic          rx_valid;
    logic          rx_ready;
    logic          parity_err;
    logic          frame_err;
    logic          overrun_err;

    int n_cmp = 0;
    int n_err = 0;
    int frame_cnt = 0;
    int ovr_cnt = 0;

    always #5 clk = ~clk;

    uart_rx_os #(.DATA_BITS(DB), .OVERSAMPLE(OS), .STOP_BITS(SB), .PARITY_ODD(PODD)) dut (
        .clk         (clk),
        .rst         (rst),
        .os_tick     (os_tick),
        .rx          (rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_err  (parity_err),
        .frame_err   (frame_err),
        .overrun_err (overrun_err)
    );

    // Pulse counters for the one-cycle error outputs.
    always @(posedge clk) begin
        if (!rst) begin
            if (frame_err)   frame_cnt <= frame_cnt + 1;
            if (overrun_err) ovr_cnt   <= ovr_cnt + 1;
        end
    end

    // One oversample period: line held at lvl for 4 clocks, tick on the last one.
    task automatic tick_once(input logic lvl);
        rx = lvl;
        repeat (3) @(posedge clk);
        #1 os_tick = 1'b1;
        @(posedge clk);
        #1 os_tick = 1'b0;
    endtask

    task automatic drive_ticks(input logic lvl, input int n);
        for (int i = 0; i < n; i++) tick_once(lvl);
    endtask

    // Serial frame: one idle bit, start, data LSB first, optional parity, stop bits.
    // glitch_idx selects a frame bit whose level is inverted only at sample M-1.
    task automatic send_frame(input logic [DB-1:0] d, input logic par_lvl,
                              input logic stop_lvl, input int glitch_idx);
        logic lv[$];
        lv.push_back(1'b0);
        for (int i = 0; i < DB; i++) lv.push_back(d[i]);
        if (PAR_EN) lv.push_back(par_lvl);
        for (int i = 0; i < SB; i++) lv.push_back(stop_lvl);
        drive_ticks(1'b1, OS);
        for (int b = 0; b < lv.size(); b++) begin
            for (int t = 0; t < OS; t++) begin
                if (b == glitch_idx && t == M - 1) tick_once(~lv[b]);
                else tick_once(lv[b]);
            end
        end
        $display("tb: frame data=%02h par=%0b stop=%0b glitch=%0d", d, par_lvl, stop_lvl, glitch_idx);
    endtask

    task automatic accept();
        rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
    endtask

    function automatic logic exp_par_err(input logic [DB-1:0] d, input logic pb);
        if (!PAR_EN) return 1'b0;
        return ((($countones(d) + int'(pb)) % 2) != PODD);
    endfunction

    task automatic test_reset();
        n_cmp++; if (rx_data !== '0)     begin n_err++; $display("FAIL reset_data: got %h want 00", rx_data); end
        n_cmp++; if (rx_valid !== 1'b0)  begin n_err++; $display("FAIL reset_valid: got %b want 0", rx_valid); end
        n_cmp++; if (parity_err !== 1'b0) begin n_err++; $display("FAIL reset_parity: got %b want 0", parity_err); end
        n_cmp++; if (frame_err !== 1'b0) begin n_err++; $display("FAIL reset_frame: got %b want 0", frame_err); end
        n_cmp++; if (overrun_err !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", overrun_err); end
    endtask

    task automatic test_basic();
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL basic_valid: got %b want 1", rx_valid); end
        n_cmp++; if (rx_data !== 8'hA5) begin n_err++; $display("FAIL basic_data: got %h want a5", rx_data); end
        repeat (20) @(posedge clk);
        #1;
        n_cmp++; if (rx_valid !== 1'b1) begin n_err++; $display("FAIL basic_hold: got %b want 1", rx_valid); end
        accept();
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL basic_clear: got %b want 0", rx_valid); end
    endtask

    task automatic test_glitch_start();
        logic [DB-1:0] d;
        int f0;
        f0 = frame_cnt;
        drive_ticks(1'b1, OS);
        drive_ticks(1'b0, 4);
        drive_ticks(1'b1, 2 * OS);
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL glitch_valid: got %b want 0", rx_valid); end
        n_cmp++; if (frame_cnt !== f0) begin n_err++; $display("FAIL glitch_frame: got %0d want %0d", frame_cnt, f0); end
        d = DB'($urandom);
        send_frame(d, ^d, 1'b1, -1);
        n_cmp++; if (rx_data !== d || rx_valid !== 1'b1) begin
            n_err++; $display("FAIL glitch_next: got %h/%b want %h/1", rx_data, rx_valid, d); end
        accept();
    endtask

    task automatic test_framing();
        int f0;
        f0 = frame_cnt;
        send_frame(8'h3C, ^8'h3C, 1'b0, -1);
        drive_ticks(1'b0, 20 * OS);
        drive_ticks(1'b1, 2 * OS);
        n_cmp++; if (frame_cnt !== f0 + 1) begin n_err++; $display("FAIL frame_pulses: got %0d want %0d", frame_cnt - f0, 1); end
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL frame_valid: got %b want 0", rx_valid); end
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        n_cmp++; if (rx_data !== 8'h5A || rx_valid !== 1'b1) begin
            n_err++; $display("FAIL frame_next: got %h/%b want 5a/1", rx_data, rx_valid); end
        n_cmp++; if (frame_cnt !== f0 + 1) begin n_err++; $display("FAIL frame_extra: got %0d want %0d", frame_cnt - f0, 1); end
        accept();
    endtask

    task automatic test_overrun();
        int o0;
        o0 = ovr_cnt;
        send_frame(8'h11, 1'b0, 1'b1, -1);
        n_cmp++; if (ovr_cnt !== o0) begin n_err++; $display("FAIL ovr_early: got %0d want %0d", ovr_cnt - o0, 0); end
        send_frame(8'h22, 1'b0, 1'b1, -1);
        n_cmp++; if (ovr_cnt !== o0 + 1) begin n_err++; $display("FAIL ovr_pulses: got %0d want %0d", ovr_cnt - o0, 1); end
        n_cmp++; if (rx_data !== 8'h11 || rx_valid !== 1'b1) begin
            n_err++; $display("FAIL ovr_keep: got %h/%b want 11/1", rx_data, rx_valid); end
        accept();
        n_cmp++; if (rx_valid !== 1'b0) begin n_err++; $display("FAIL ovr_clear: got %b want 0", rx_valid); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        send_frame(8'h07, 1'b0, 1'b1, -1);
        n_cmp++; if (rx_data !== 8'h07 || parity_err !== exp_par_err(8'h07, 1'b0)) begin
            n_err++; $display("FAIL par_bad: got %h/%b want 07/%b", rx_data, parity_err, exp_par_err(8'h07, 1'b0)); end
        accept();
        send_frame(8'h07, 1'b1, 1'b1, -1);
        n_cmp++; if (rx_data !== 8'h07 || parity_err !== exp_par_err(8'h07, 1'b1)) begin
            n_err++; $display("FAIL par_good: got %h/%b want 07/%b", rx_data, parity_err, exp_par_err(8'h07, 1'b1)); end
        accept();
    endtask
`endif

    task automatic test_vote();
        send_frame(8'h00, 1'b0, 1'b1, 1 + 3);
        n_cmp++; if (rx_data !== 8'h00 || rx_valid !== 1'b1) begin
            n_err++; $display("FAIL vote_data: got %h/%b want 00/1", rx_data, rx_valid); end
        accept();
    endtask

    task automatic test_reset_mid();
        int f0;
        int o0;
        send_frame(8'h96, 1'b0, 1'b1, -1);
        drive_ticks(1'b1, OS);
        drive_ticks(1'b0, OS);              // start bit
        drive_ticks(1'b0, 3 * OS);          // part of the data
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        f0 = frame_cnt;
        o0 = ovr_cnt;
        n_cmp++; if (rx_data !== '0 || rx_valid !== 1'b0 || parity_err !== 1'b0) begin
            n_err++; $display("FAIL rstmid_out: got %h/%b/%b want 00/0/0", rx_data, rx_valid, parity_err); end
        drive_ticks(1'b1, 2 * OS);
        n_cmp++; if (frame_cnt !== f0 || ovr_cnt !== o0 || rx_valid !== 1'b0) begin
            n_err++; $display("FAIL rstmid_quiet: got fe=%0d ov=%0d v=%b want 0/0/0", frame_cnt - f0, ovr_cnt - o0, rx_valid); end
        send_frame(8'hC3, 1'b0, 1'b1, -1);
        n_cmp++; if (rx_data !== 8'hC3 || rx_valid !== 1'b1) begin
            n_err++; $display("FAIL rstmid_next: got %h/%b want c3/1", rx_data, rx_valid); end
        accept();
    endtask

    task automatic test_random();
        logic [DB-1:0] d;
        logic          pb;
        for (int k = 0; k < 10; k++) begin
            d  = DB'($urandom);
            pb = 1'($urandom_range(0, 1));
            send_frame(d, pb, 1'b1, -1);
            n_cmp++; if (rx_data !== d || rx_valid !== 1'b1) begin
                n_err++; $display("FAIL rand_data[%0d]: got %h/%b want %h/1", k, rx_data, rx_valid, d); end
            n_cmp++; if (parity_err !== exp_par_err(d, pb)) begin
                n_err++; $display("FAIL rand_par[%0d]: got %b want %b", k, parity_err, exp_par_err(d, pb)); end
            accept();
        end
    endtask

    initial begin
        rst      = 1'b1;
        rx       = 1'b1;
        os_tick  = 1'b0;
        rx_ready = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        test_reset();
        rst = 1'b0;
        test_basic();
        test_glitch_start();
        test_framing();
        test_overrun();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_vote();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised, oversampling UART receiver: the next generation of the team's UART RX path. Recovers frames of configurable data width and stop-bit count from an asynchronous `rx` line, using an oversample tick and 3-sample majority voting. It presents received words through a valid/ready holding register with parity, framing and overrun status. It sits between the shared baud generator (oversample tick output) and the UART host/FIFO logic.

## Interface
- `DATA_BITS`, 8: data bits per frame; legal range 5–9.
- `OVERSAMPLE`, 16: `os_tick` pulses per bit; even, ≥8.
- `STOP_BITS`, 1: stop bits checked; 1 or 2.
- `PARITY_ODD`, 0: 0 = even parity, 1 = odd parity. Only meaningful with `UART_RX_PARITY_EN`.
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `os_tick`  in  1  one-cycle pulse at baud × `OVERSAMPLE`.
- `rx`  in  1  asynchronous serial line; idle high.
- `rx_data`  out  `DATA_BITS`  received word; valid while `rx_valid`.
- `rx_valid`  out  1  word available; held until accepted.
- `rx_ready`  in  1  consumer accepts when `rx_valid & rx_ready`.
- `parity_err`  out  1  parity status of the held word; qualified by `rx_valid`.
- `frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun_err`  out  1  one-cycle pulse: frame completed while `rx_valid` was still high.

## Operation
- **Synchronizer.** `rx` passes through a 2-flop synchronizer that resets to 1. All logic uses the synced line `rxs`.
- **Bit decision.** Sample counter `c` advances on each `os_tick` and wraps at `OVERSAMPLE-1`. With M = `OVERSAMPLE/2`, `rxs` is sampled at c = M-2, M-1 and M. The bit value is the majority of those three samples, decided on the tick where c = M.
- **IDLE.** A falling edge on `rxs` sets c to 0 and moves to START.
- **START.** Voted 0 → DATA, with c continuing so that each later decision falls OVERSAMPLE ticks apart. Voted 1 → IDLE (glitch rejected).
- **DATA.** Shift in `DATA_BITS` decisions, LSB first, then go to PARITY (macro on) or STOP.
- **PARITY.** One decision. Error if the parity of the data bits plus the parity bit mismatches `PARITY_ODD`. Then STOP.
- **STOP.** `STOP_BITS` decisions.
  - All 1: load the holding register, then go to IDLE.
  - Any 0: pulse `frame_err`, do not load, go to BREAK.
- **BREAK.** Stay until `rxs` = 1, then IDLE. A held-low line therefore produces exactly one `frame_err`.
- **Holding register.** On load, `rx_valid` ← 1, `rx_data` ← word, `parity_err` ← computed error. A handshake clears `rx_valid`.
- **Overrun.** A load while `rx_valid` = 1 and no handshake in the same cycle: pulse `overrun_err`, discard the new word, keep the old word and status. A load in the same cycle as a handshake succeeds.
- **Reset values.** `rx_data` = 0, `rx_valid` = 0, `parity_err` = 0, `frame_err` = 0, `overrun_err` = 0. State is IDLE, c = 0, synchronizer = 1.
- **Reset mid-frame.** The frame is abandoned, with no error pulse.

## Timing
- `rx_valid`, `frame_err` and `overrun_err` assert the clk cycle after the `os_tick` carrying the final stop decision.
- From the start edge reaching `rxs`, the last decision comes (1 + `DATA_BITS` + P + `STOP_BITS`) × `OVERSAMPLE` − M `os_tick`s later, where P = 1 if parity is enabled, else 0.
- Synchronizer adds 2 clk cycles of input latency.
- No `os_tick` → the FSM holds state. The handshake still works.

## Configuration
- **`UART_RX_PARITY_EN` defined:** the PARITY state exists, one parity bit is expected after the data bits, and `parity_err` is computed.
- **Not defined:** PARITY state and logic are removed, and `parity_err` is tied to 0.

## Structure
- Package `uart_pkg` holds:
  - the state enum (IDLE, START, DATA, PARITY, STOP, BREAK);
  - the majority-vote function;
  - parameter legality constants, shared with the future TX.
- One sub-module, `uart_rx_sampler`, contains the synchronizer, the sample counter and the 3-sample vote. It outputs `rxs_fall`, `bit_strobe` and `bit_val`.

## Test plan
Defaults unless stated: `OVERSAMPLE`=16, `DATA_BITS`=8, `STOP_BITS`=1.
- Send 0xA5 8N1 with `rx_ready`=0 → `rx_data`=0xA5, `rx_valid` held; `rx_ready` pulse → `rx_valid`=0 next cycle.
- `rx` low for 4 `os_tick`s, then high → no `rx_valid`, FSM back in IDLE.
- Send 0x3C with stop bit 0, line held low 20 bits → single `frame_err` pulse, no `rx_valid`; after line high, 0x5A received correctly.
- Send 0x11, then 0x22, with `rx_ready`=0 → `rx_data`=0x11, one `overrun_err` pulse at the 0x22 stop.
- Macro on, `PARITY_ODD`=0: send 0x07 with parity bit 0 → `rx_data`=0x07, `parity_err`=1; with parity bit 1 → `parity_err`=0.
- Data bit 3 of 0x00 forced high only at sample c=M-1 → `rx_data`=0x00 (vote). Separately, assert `rst` mid-data → all outputs 0, next frame 0xC3 received correctly.
